// File: rtl/phase_interpolator.sv
// Divides base_clk by 2**SEL_W and emits a 50%-duty clock offset by phase_cur base_clk periods.
// Optional macro PI_SLEW_EN: phase_cur slews one step per output period instead of jumping.
module phase_interpolator #(
    parameter int unsigned SEL_W = 6
) (
    input  logic             base_clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] phase_sel,
    output logic             interp_clk,
    output logic [SEL_W-1:0] phase_cur,
    output logic             phase_busy
);

    localparam int unsigned DIV  = 2 ** SEL_W;
    localparam int unsigned HALF = DIV / 2;

    logic [SEL_W-1:0] cnt_q,   cnt_d;
    logic [SEL_W-1:0] phase_q, phase_d;
    logic             clk_q,   clk_d;
    logic [SEL_W-1:0] offs;
    logic [SEL_W-1:0] fwd;
    logic             wrap;

    // Next-state: output level from offset counter, phase update only at wrap
    always_comb begin
        cnt_d   = cnt_q + SEL_W'(1);
        phase_d = phase_q;
        offs    = cnt_q - phase_q;
        fwd     = phase_sel - phase_q;
        wrap    = (cnt_q == SEL_W'(DIV - 1));
        clk_d   = (offs < SEL_W'(HALF));
`ifdef PI_SLEW_EN
        // Shortest modulo path; a tie at exactly half a period resolves upward
        if (wrap && (fwd != '0)) begin
            if (fwd <= SEL_W'(HALF)) begin
                phase_d = phase_q + SEL_W'(1);
            end else begin
                phase_d = phase_q - SEL_W'(1);
            end
        end
`else
        if (wrap) begin
            phase_d = phase_sel;
        end
`endif
    end

    always_ff @(posedge base_clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= '0;
            clk_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            clk_q   <= clk_d;
        end
    end

    assign interp_clk = clk_q;
    assign phase_cur  = phase_q;
    assign phase_busy = !rst && (phase_q != phase_sel);

endmodule

// File: tb/tb_phase_interpolator.sv
// Bench for phase_interpolator (SEL_W=6): directed scenarios plus random phase/reset traffic
// compared every cycle against an arithmetic reference model.
module tb_phase_interpolator;

    localparam int SEL_W = 6;
    localparam int DIV   = 64;

    logic             base_clk = 1'b0;
    logic             rst      = 1'b1;
    logic [SEL_W-1:0] phase_sel = '0;
    logic             interp_clk;
    logic [SEL_W-1:0] phase_cur;
    logic             phase_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: counter position, applied phase, output level
    int m_cnt = 0;
    int m_ph  = 0;
    int m_clk = 0;

    phase_interpolator #(.SEL_W(SEL_W)) dut (
        .base_clk   (base_clk),
        .rst        (rst),
        .phase_sel  (phase_sel),
        .interp_clk (interp_clk),
        .phase_cur  (phase_cur),
        .phase_busy (phase_busy)
    );

    always #10 base_clk = ~base_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int modd(input int x);
        return ((x % DIV) + DIV) % DIV;
    endfunction

    // Phase applied after a wrap, given the request and the current phase
    function automatic int next_phase(input int req, input int cur);
        int up;
`ifdef PI_SLEW_EN
        up = modd(req - cur);
        if (up == 0)             return cur;
        else if (up <= DIV - up) return modd(cur + 1);
        else                     return modd(cur - 1);
`else
        up = 0;
        return req + up;
`endif
    endfunction

    // One base_clk edge: advance the model with pre-edge values, then compare
    task automatic step();
        int sel;
        @(posedge base_clk);
        sel = int'(phase_sel);
        if (rst) begin
            m_cnt = 0;
            m_ph  = 0;
            m_clk = 0;
        end else begin
            m_clk = (modd(m_cnt - m_ph) < DIV / 2) ? 1 : 0;
            if (m_cnt == DIV - 1) m_ph = next_phase(sel, m_ph);
            m_cnt = modd(m_cnt + 1);
        end
        #1;
        check("interp_clk", int'(interp_clk), m_clk);
        check("phase_cur", int'(phase_cur), m_ph);
        check("phase_busy", int'(phase_busy), (rst || (m_ph == int'(phase_sel))) ? 0 : 1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_cnt(input int c);
        for (int i = 0; i < 2 * DIV && m_cnt != c; i++) step();
    endtask

    initial begin
        // Reset held for two edges
        rst = 1'b1;
        phase_sel = '0;
        run(2);
        check("rst_clk", int'(interp_clk), 0);
        check("rst_busy", int'(phase_busy), 0);

        // Free run at phase 0: high right after release
        rst = 1'b0;
        step();
        check("first_hi", int'(interp_clk), 1);
        run(2 * DIV);

        // Request 63 mid-period; busy until the wrap applies it
        run_to_cnt(10);
        phase_sel = 6'd63;
        #1;
        check("busy_req", int'(phase_busy), 1);
        run(3 * DIV);
        for (int i = 0; i < 40 * DIV && m_ph != 63; i++) step();
        check("settle63", int'(phase_cur), 63);

        // Back to 0, then a 0->42->0 glitch inside one period is ignored
        phase_sel = '0;
        for (int i = 0; i < 40 * DIV && m_ph != 0; i++) step();
        run_to_cnt(5);
        phase_sel = 6'd42;
        run(15);
        phase_sel = '0;
        run(2 * DIV);
        check("glitch_hold", int'(phase_cur), 0);

        // Settle at 42, then reset mid-period
        phase_sel = 6'd42;
        for (int i = 0; i < 40 * DIV && m_ph != 42; i++) step();
        check("settle42", int'(phase_cur), 42);
        run_to_cnt(20);
        rst = 1'b1;
        step();
        check("midrst_ph", int'(phase_cur), 0);
        check("midrst_clk", int'(interp_clk), 0);
        rst = 1'b0;
        phase_sel = '0;
        run(DIV);

        // Increment tie case (distance exactly half)
        phase_sel = 6'd32;
        for (int i = 0; i < 40 * DIV && m_ph != 32; i++) step();
        check("settle32", int'(phase_cur), 32);

        // Random phase requests and occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) phase_sel = SEL_W'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        run(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
